// File: rtl/ps2_keystroke_if.sv
// PS/2 line inputs and decoded keystroke outputs of the snake input stage.
interface ps2_keystroke_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [12:0] keystroke;
  logic        code_valid;
  logic [7:0]  code;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keystroke, code_valid, code, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keystroke, code_valid, code, frame_err
  );
endinterface

// File: rtl/ps2_keystroke.sv
// PS/2 set-2 receiver: line conditioning, 11-bit deframer, prefix tracking
// and key-to-keystroke mapping for the snake core.
module ps2_keystroke #(
  parameter int unsigned filt_len    = 8,
  parameter int unsigned timeout_cyc = 100000,
  parameter int unsigned restart_len = 5
) (
  input  logic           clk_raw,
  input  logic           rst,
  ps2_keystroke_if.slave bus
);

  localparam int unsigned filt_w  = $clog2(filt_len + 1);
  localparam int unsigned tmo_w   = $clog2(timeout_cyc + 1);
  localparam int unsigned pulse_w = $clog2(restart_len + 1);

  localparam logic [1:0] fr_idle = 2'd0;
  localparam logic [1:0] fr_data = 2'd1;
  localparam logic [1:0] fr_par  = 2'd2;
  localparam logic [1:0] fr_stop = 2'd3;

  localparam logic [1:0] sc_base    = 2'd0;
  localparam logic [1:0] sc_ext     = 2'd1;
  localparam logic [1:0] sc_brk     = 2'd2;
  localparam logic [1:0] sc_ext_brk = 2'd3;

  logic              clk_s1, clk_s2, data_s1, data_s2;
  logic              filt_clk, filt_prev, fall;
  logic [filt_w-1:0] filt_cnt;

  logic [1:0]       fr_state, fr_state_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shreg, shreg_d;
  logic [tmo_w-1:0] idle_cnt, idle_cnt_d;
  logic [7:0]       code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [1:0]         sc_state, sc_state_d;
  logic [3:0]         p1_q, p1_d, p2_q, p2_d;
  logic               pause_q, pause_d, run_q, run_d;
  logic               restart_q, restart_d;
  logic [pulse_w-1:0] pulse_cnt, pulse_cnt_d;

  // Accept a requested direction unless it is the exact reverse of the current one.
  function automatic logic [3:0] steer(input logic [3:0] cur, input logic [3:0] req);
    return (req == {cur[2], cur[3], cur[0], cur[1]}) ? cur : req;
  endfunction

  // Two-stage synchronisers on both PS/2 lines.
  always_ff @(posedge clk_raw) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: a new clock level needs filt_len consecutive samples.
  always_ff @(posedge clk_raw) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == filt_w'(filt_len - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + filt_w'(1);
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Deframer state and registered strobes.
  always_ff @(posedge clk_raw) begin
    if (rst) begin
      fr_state     <= fr_idle;
      bit_cnt      <= '0;
      shreg        <= '0;
      idle_cnt     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      fr_state     <= fr_state_d;
      bit_cnt      <= bit_cnt_d;
      shreg        <= shreg_d;
      idle_cnt     <= idle_cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Deframer next state: start, 8 data bits LSB first, odd parity, stop; idle timeout.
  always_comb begin
    fr_state_d   = fr_state;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    idle_cnt_d   = (fr_state == fr_idle) ? '0 : idle_cnt + tmo_w'(1);
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      idle_cnt_d = '0;
      case (fr_state)
        fr_idle: begin
          if (!data_s2) begin
            fr_state_d = fr_data;
            bit_cnt_d  = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        fr_data: begin
          shreg_d   = {data_s2, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) fr_state_d = fr_par;
        end
        fr_par: begin
          if (^{shreg, data_s2}) begin
            fr_state_d = fr_stop;
          end else begin
            fr_state_d  = fr_idle;
            frame_err_d = 1'b1;
          end
        end
        default: begin
          fr_state_d = fr_idle;
          if (data_s2) begin
            code_valid_d = 1'b1;
            code_d       = shreg;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end else if (fr_state != fr_idle && idle_cnt == tmo_w'(timeout_cyc)) begin
      fr_state_d  = fr_idle;
      idle_cnt_d  = '0;
      frame_err_d = 1'b1;
    end
  end

  // Scancode tracker and keystroke level/pulse registers.
  always_ff @(posedge clk_raw) begin
    if (rst) begin
      sc_state  <= sc_base;
      p1_q      <= 4'b0001;
      p2_q      <= 4'b1000;
      pause_q   <= 1'b0;
      run_q     <= 1'b1;
      restart_q <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      sc_state  <= sc_state_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      pause_q   <= pause_d;
      run_q     <= run_d;
      restart_q <= restart_d;
      pulse_cnt <= pulse_cnt_d;
    end
  end

  // Prefix handling, make-code map and restart pulse timer.
  always_comb begin
    sc_state_d  = sc_state;
    p1_d        = p1_q;
    p2_d        = p2_q;
    pause_d     = pause_q;
    run_d       = run_q;
    pulse_cnt_d = (pulse_cnt != '0) ? pulse_cnt - pulse_w'(1) : '0;
    if (code_valid_q) begin
      case (sc_state)
        sc_base: begin
          if (code_q == 8'hE0) begin
            sc_state_d = sc_ext;
          end else if (code_q == 8'hF0) begin
            sc_state_d = sc_brk;
          end else begin
            case (code_q)
              8'h1D:   p1_d = steer(p1_q, 4'b1000);
              8'h1B:   p1_d = steer(p1_q, 4'b0100);
              8'h1C:   p1_d = steer(p1_q, 4'b0010);
              8'h23:   p1_d = steer(p1_q, 4'b0001);
              8'h29:   pause_d = ~pause_q;
              8'h76:   run_d = ~run_q;
              8'h5A:   pulse_cnt_d = pulse_w'(restart_len);
              default: ;
            endcase
          end
        end
        sc_ext: begin
          if (code_q == 8'hF0) begin
            sc_state_d = sc_ext_brk;
          end else begin
            sc_state_d = sc_base;
            case (code_q)
              8'h75:   p2_d = steer(p2_q, 4'b1000);
              8'h72:   p2_d = steer(p2_q, 4'b0100);
              8'h6B:   p2_d = steer(p2_q, 4'b0010);
              8'h74:   p2_d = steer(p2_q, 4'b0001);
              default: ;
            endcase
          end
        end
        default: sc_state_d = sc_base;
      endcase
    end
    restart_d = (pulse_cnt_d != '0);
  end

  assign bus.keystroke  = {run_q, 2'b00, pause_q, restart_q, p2_q, p1_q};
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keystroke.sv
// Scoreboard bench for ps2_keystroke: PS/2 frames in, codes and keystroke levels out.
module tb_ps2_keystroke;

  localparam int unsigned half = 20;
  localparam int unsigned gap  = 40;
  localparam int unsigned tmo  = 2000;
  localparam int unsigned rlen = 600;
  localparam logic [12:0] ks_rst  = 13'b1_0000_1000_0001;
  localparam logic [12:0] ks_mask = 13'h1EFF;

  typedef struct packed {
    logic [7:0]  code;
    logic [12:0] ks;
  } exp_t;

  logic clk_raw = 1'b0;
  logic rst = 1'b1;
  ps2_keystroke_if bus();

  ps2_keystroke #(.filt_len(8), .timeout_cyc(tmo), .restart_len(rlen)) dut (
    .clk_raw (clk_raw),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_raw = ~clk_raw;

  int vectors = 0;
  int miscompares = 0;

  exp_t        exp_q[$];
  logic [7:0]  obs_code_q[$];
  logic [12:0] obs_ks_q[$];
  int          valid_cyc_q[$];
  int cyc = 0, n_valid = 0, n_err = 0, pulse_hi = 0, rise_cyc = -1;
  logic cap_ks = 1'b0, ks8_prev = 1'b0;

  // Reference model state.
  logic [3:0] m_p1, m_p2;
  logic m_pause, m_run;
  int m_st;

  // Output monitor: records strobes, captured codes and the following keystroke.
  always @(negedge clk_raw) begin
    cyc <= cyc + 1;
    if (rst) begin
      cap_ks   <= 1'b0;
      ks8_prev <= 1'b0;
    end else begin
      if (bus.code_valid) begin
        obs_code_q.push_back(bus.code);
        valid_cyc_q.push_back(cyc);
        n_valid <= n_valid + 1;
      end
      cap_ks <= bus.code_valid;
      if (cap_ks) obs_ks_q.push_back(bus.keystroke);
      if (bus.frame_err) n_err <= n_err + 1;
      if (bus.keystroke[8]) begin
        pulse_hi <= pulse_hi + 1;
        if (!ks8_prev) rise_cyc <= cyc;
      end
      ks8_prev <= bus.keystroke[8];
    end
  end

  task automatic model_reset();
    m_p1 = 4'b0001; m_p2 = 4'b1000; m_pause = 1'b0; m_run = 1'b1; m_st = 0;
  endtask

  function automatic logic [3:0] m_turn(input logic [3:0] cur, input logic [3:0] req);
    logic opposite;
    opposite = (cur[3] & req[2]) | (cur[2] & req[3]) | (cur[1] & req[0]) | (cur[0] & req[1]);
    return opposite ? cur : req;
  endfunction

  function automatic logic [12:0] model_ks();
    return {m_run, 2'b00, m_pause, 1'b0, m_p2, m_p1};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (m_st == 0) begin
      if (b == 8'hE0) m_st = 1;
      else if (b == 8'hF0) m_st = 2;
      else case (b)
        8'h1D: m_p1 = m_turn(m_p1, 4'b1000);
        8'h1B: m_p1 = m_turn(m_p1, 4'b0100);
        8'h1C: m_p1 = m_turn(m_p1, 4'b0010);
        8'h23: m_p1 = m_turn(m_p1, 4'b0001);
        8'h29: m_pause = ~m_pause;
        8'h76: m_run = ~m_run;
        default: ;
      endcase
    end else if (m_st == 1) begin
      if (b == 8'hF0) m_st = 2;
      else begin
        m_st = 0;
        case (b)
          8'h75: m_p2 = m_turn(m_p2, 4'b1000);
          8'h72: m_p2 = m_turn(m_p2, 4'b0100);
          8'h6B: m_p2 = m_turn(m_p2, 4'b0010);
          8'h74: m_p2 = m_turn(m_p2, 4'b0001);
          default: ;
        endcase
      end
    end else begin
      m_st = 0;
    end
  endtask

  // Drive nbits of an 11-bit frame; complete good frames go to the scoreboard.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    exp_t e;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11 && !bad_par) begin
      model_byte(b);
      e.code = b;
      e.ks = model_ks();
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      repeat (half) @(negedge clk_raw);
      bus.ps2_clk = 1'b0;
      repeat (half) @(negedge clk_raw);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (gap) @(negedge clk_raw);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (4) @(negedge clk_raw);
    vectors++;
    if (bus.keystroke !== ks_rst) begin
      miscompares++; $display("FAIL reset_ks: got %b want %b", bus.keystroke, ks_rst);
    end
    vectors++;
    if (bus.code_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", bus.code_valid);
    end
    vectors++;
    if (bus.code !== 8'h00) begin
      miscompares++; $display("FAIL reset_code: got %h want 00", bus.code);
    end
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", bus.frame_err);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk_raw);
  endtask

  task automatic test_p1_dir();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    send_frame(8'h1D, 1'b0, 11);
    send_frame(8'h1B, 1'b0, 11);
    send_frame(8'h1D, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL p1_dir: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
    vectors++;
    if (bus.keystroke[3:0] !== 4'b0010) begin
      miscompares++; $display("FAIL p1_final: got %b want 0010", bus.keystroke[3:0]);
    end
  endtask

  task automatic test_p2_dir();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h72, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL p2_dir: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
    vectors++;
    if (bus.keystroke[7:4] !== 4'b0010) begin
      miscompares++; $display("FAIL p2_final: got %b want 0010", bus.keystroke[7:4]);
    end
  endtask

  task automatic test_restart();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    int hi0, t1, t2;
    hi0 = pulse_hi;
    send_frame(8'h5A, 1'b0, 11);
    t1 = valid_cyc_q[$];
    repeat (rlen + 20) @(negedge clk_raw);
    vectors++;
    if (rise_cyc !== t1 + 1) begin
      miscompares++; $display("FAIL restart_rise: got cycle %0d want %0d", rise_cyc, t1 + 1);
    end
    vectors++;
    if (pulse_hi - hi0 !== rlen) begin
      miscompares++; $display("FAIL restart_width: got %0d want %0d", pulse_hi - hi0, rlen);
    end
    // Back-to-back Enter: the second strobe reloads the pulse.
    hi0 = pulse_hi;
    send_frame(8'h5A, 1'b0, 11);
    send_frame(8'h5A, 1'b0, 11);
    t1 = valid_cyc_q[$-1];
    t2 = valid_cyc_q[$];
    repeat (rlen + 20) @(negedge clk_raw);
    vectors++;
    if (pulse_hi - hi0 !== t2 - t1 + rlen) begin
      miscompares++; $display("FAIL restart_extend: got %0d want %0d", pulse_hi - hi0, t2 - t1 + rlen);
    end
    vectors++;
    if (bus.keystroke[8] !== 1'b0) begin
      miscompares++; $display("FAIL restart_end: got %b want 0", bus.keystroke[8]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL restart_sb: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
  endtask

  task automatic test_pause_parity();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h29, 1'b1, 11);
    vectors++;
    if (n_err - e0 < 1 || n_valid != v0) begin
      miscompares++; $display("FAIL bad_parity: got errs %0d valids %0d want errs >=1 valids 0", n_err - e0, n_valid - v0);
    end
    vectors++;
    if (bus.keystroke[9] !== 1'b0) begin
      miscompares++; $display("FAIL pause_kept: got %b want 0", bus.keystroke[9]);
    end
    send_frame(8'h29, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h29, 1'b0, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL pause_sb: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
    vectors++;
    if (bus.keystroke[9] !== 1'b1) begin
      miscompares++; $display("FAIL pause_final: got %b want 1", bus.keystroke[9]);
    end
  endtask

  task automatic test_timeout();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h76, 1'b0, 5);
    repeat (tmo / 2) @(negedge clk_raw);
    vectors++;
    if (n_err != e0) begin
      miscompares++; $display("FAIL timeout_early: got errs %0d want 0", n_err - e0);
    end
    repeat (tmo) @(negedge clk_raw);
    vectors++;
    if (n_err - e0 != 1 || n_valid != v0) begin
      miscompares++; $display("FAIL timeout_err: got errs %0d valids %0d want errs 1 valids 0", n_err - e0, n_valid - v0);
    end
    send_frame(8'h76, 1'b0, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL timeout_sb: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
    vectors++;
    if (bus.keystroke[12] !== 1'b0) begin
      miscompares++; $display("FAIL run_toggle: got %b want 0", bus.keystroke[12]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [7:0] oc; logic [12:0] ok;
    int v0;
    send_frame(8'h5A, 1'b0, 11);
    send_frame(8'h1D, 1'b0, 6);
    vectors++;
    if (bus.keystroke[8] !== 1'b1) begin
      miscompares++; $display("FAIL pulse_before_rst: got %b want 1", bus.keystroke[8]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL rstmid_sb: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
    rst = 1'b1;
    @(negedge clk_raw);
    vectors++;
    if (bus.keystroke !== ks_rst) begin
      miscompares++; $display("FAIL rst_mid_ks: got %b want %b", bus.keystroke, ks_rst);
    end
    rst = 1'b0;
    model_reset();
    v0 = n_valid;
    repeat (300) @(negedge clk_raw);
    vectors++;
    if (n_valid != v0) begin
      miscompares++; $display("FAIL rst_partial: got %0d valids want 0", n_valid - v0);
    end
    send_frame(8'h1D, 1'b0, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      oc = (obs_code_q.size() > 0) ? obs_code_q.pop_front() : 8'hxx;
      ok = (obs_ks_q.size() > 0) ? obs_ks_q.pop_front() : 13'hxxxx;
      if (oc !== e.code || (ok & ks_mask) !== e.ks) begin
        miscompares++; $display("FAIL rst_recover: got code %h ks %b want code %h ks %b", oc, ok & ks_mask, e.code, e.ks);
      end
    end
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_p1_dir();
    test_p2_dir();
    test_restart();
    test_pause_parity();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

endmodule
